// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit in front of a single-cycle ARM core. It keeps at most
// one word request outstanding towards an instruction memory whose acknowledge
// latency can vary, and it prefetches sequential words into a small FIFO.
// The core's current pc is compared combinationally against the FIFO head. A
// non-sequential pc (branch) flushes the FIFO and restarts fetching at the new
// address.
//
// Parameters
//   DEPTH      prefetch buffer entries (1..4)
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  word driven on instr while instr_valid is low
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low reset
//   pc[31:0]     in   address the core wants this cycle (bits [1:0] ignored)
//   stall        in   core is not consuming this cycle (no pop)
//   instr[31:0]  out  instruction for pc, NOP_INSTR when not valid
//   instr_valid  out  instr is the word at pc
//   imem_req     out  registered memory request
//   imem_addr    out  registered request address, held until acknowledged
//   imem_ack     in   memory accepted the request, imem_rdata valid
//   imem_rdata   in   read data, sampled only when imem_req & imem_ack
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,  // no request on the bus
        S_REQ     = 2'd1,  // request whose data will be kept
        S_DISCARD = 2'd2   // stale request after a redirect, data dropped
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [31:0]        fetch_addr_q, fetch_addr_d;
    logic               imem_req_q,   imem_req_d;
    logic [31:0]        imem_addr_q,  imem_addr_d;
    logic [CNT_W-1:0]   count_q,      count_d;
    logic [PTR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,     wr_ptr_d;

    // Buffer storage carries no reset: an entry is only looked at while count
    // says it holds a pushed word.
    logic [31:0]        buf_addr_q [DEPTH];
    logic [31:0]        buf_data_q [DEPTH];

    // -------------------------------------------------------------------------
    // Lookup against the buffer head
    // -------------------------------------------------------------------------
    logic [31:0] pc_al;
    logic [31:0] head_addr;
    logic [31:0] head_data;
    logic        buf_nonempty;
    logic        hit;
    logic        redirect;
    logic        pop;
    logic        push;
    logic        space;
    logic        pc_unused;

    // The core only issues word addresses; the low bits take no part in the
    // compare so a misaligned pc behaves like its aligned word.
    assign pc_al     = {pc[31:2], 2'b00};
    assign pc_unused = ^pc[1:0];

    assign head_addr    = buf_addr_q[rd_ptr_q];
    assign head_data    = buf_data_q[rd_ptr_q];
    assign buf_nonempty = (count_q != '0);
    assign hit          = buf_nonempty && (head_addr == pc_al);

    // With words buffered, anything other than the head is a branch. With an
    // empty buffer, fetch_addr is the address already requested (or about to
    // be), so a pc that differs from it is a branch as well.
    assign redirect = buf_nonempty ? (head_addr != pc_al)
                                   : (fetch_addr_q != pc_al);

    assign pop  = hit && !stall;
    // Data of a request that coincides with a redirect belongs to the old
    // instruction stream and is dropped.
    assign push = (state_q == S_REQ) && imem_ack && !redirect;

    assign instr_valid = hit;
    assign instr       = hit ? head_data : NOP_INSTR;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin : next_state
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        imem_req_d   = imem_req_q;
        imem_addr_d  = imem_addr_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;

        if (redirect) begin
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            fetch_addr_d = pc_al;
        end else begin
            if (push) begin
                wr_ptr_d     = ptr_inc(wr_ptr_q);
                // Natural 32-bit wrap: 0xFFFF_FFFC is followed by 0.
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // A new request is only started when its word is guaranteed a slot:
        // with a single outstanding request nothing else can be pushed before
        // its acknowledge, and pops only free more room.
        space = (count_d < DEPTH_C);

        case (state_q)
            S_IDLE: begin
                if (space) begin
                    state_d     = S_REQ;
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_addr_d;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (space) begin
                        imem_addr_d = fetch_addr_d;
                    end else begin
                        state_d    = S_IDLE;
                        imem_req_d = 1'b0;
                    end
                end else if (redirect) begin
                    // The bus request cannot be withdrawn; keep it and
                    // throw its data away once it is acknowledged.
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    if (space) begin
                        state_d     = S_REQ;
                        imem_addr_d = fetch_addr_d;
                    end else begin
                        state_d    = S_IDLE;
                        imem_req_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Buffer storage: the acknowledged word is written with the address it was
    // requested from, which is what the head compare needs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= imem_addr_q;
            buf_data_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch (DEPTH=2, RESET_PC=0). Inputs change on the
// falling edge, outputs are checked 1 time unit later, so each step is one
// clock cycle counted from reset release. Memory data is a fixed function of
// the address, so the expected instruction for any pc is known up front.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    instr_fetch #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = imem_ack ? mem(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all four outputs against hand-derived values for this cycle.
    task automatic expect_out(input logic v, input logic [31:0] ipc,
                              input logic r, input logic [31:0] ad);
        logic [31:0] exp_instr;
        exp_instr = v ? mem(ipc) : NOP;
        $display("cyc %0d pc=%h stall=%b ack=%b valid=%b instr=%h req=%b addr=%h",
                 cyc, pc, stall, imem_ack, instr_valid, instr, imem_req, imem_addr);
        chk($sformatf("c%0d_valid", cyc), {31'd0, instr_valid}, {31'd0, v});
        chk($sformatf("c%0d_instr", cyc), instr, exp_instr);
        chk($sformatf("c%0d_req",   cyc), {31'd0, imem_req}, {31'd0, r});
        chk($sformatf("c%0d_addr",  cyc), imem_addr, ad);
    endtask

    task automatic step(input logic [31:0] p, input logic s, input logic a,
                        input logic v, input logic [31:0] ipc,
                        input logic r, input logic [31:0] ad);
        @(negedge clk);
        cyc++;
        pc       = p;
        stall    = s;
        imem_ack = a;
        #1;
        expect_out(v, ipc, r, ad);
    endtask

    initial begin
        reset    = 1'b0;
        pc       = 32'h0;
        stall    = 1'b0;
        imem_ack = 1'b0;

        // Held in reset with the clock running
        repeat (2) @(negedge clk);
        #1;
        expect_out(1'b0, 32'h0, 1'b0, 32'h0);

        // Cycle 0: reset released, nothing requested yet
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_out(1'b0, 32'h0, 1'b0, 32'h0);

        //    pc             stall ack   valid ipc            req   addr
        // zero-wait memory, sequential pc (cycle 3 uses misaligned pc 6)
        step(32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000);
        step(32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004);
        step(32'h0000_0006, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0008);
        step(32'h0000_0008, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_000C);
        step(32'h0000_000C, 1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0010);
        // three wait states per request
        step(32'h0000_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0014);
        step(32'h0000_0014, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0014);
        step(32'h0000_0014, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0014);
        step(32'h0000_0014, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0014);
        step(32'h0000_0014, 1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0018);
        step(32'h0000_0018, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018);
        step(32'h0000_0018, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018);
        step(32'h0000_0018, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0018);
        step(32'h0000_0018, 1'b0, 1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_001C);
        // branch to 0x8 while 0x1C pending: 0x1C held, its data dropped
        step(32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_001C);
        step(32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_001C);
        step(32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008);
        // stall lets the buffer fill with 0x8, 0xC; request stops
        step(32'h0000_0008, 1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_000C);
        step(32'h0000_0008, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_000C);
        // branch to 0x100 with a full buffer
        step(32'h0000_0100, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_000C);
        step(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100);
        step(32'h0000_0100, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0104);
        // branch to 0x200 while 0x104 pending, ack two cycles later
        step(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104);
        step(32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0104);
        step(32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104);
        step(32'h0000_0200, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0200);
        step(32'h0000_0200, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0204);
        // stall for six cycles
        step(32'h0000_0204, 1'b1, 1'b1, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0208);
        for (int i = 0; i < 5; i++) begin
            step(32'h0000_0204, 1'b1, 1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0208);
        end
        step(32'h0000_0204, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0208);
        step(32'h0000_0208, 1'b0, 1'b1, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_020C);
        step(32'h0000_020C, 1'b0, 1'b1, 1'b1, 32'h0000_020C, 1'b1, 32'h0000_0210);
        // branch coinciding with ack, then sequential wrap past 0xFFFF_FFFC
        step(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0214);
        step(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC);
        step(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004);

        // Asynchronous reset in the middle of a pending request
        #2;
        reset = 1'b0;
        #1;
        expect_out(1'b0, 32'h0, 1'b0, 32'h0000_0000);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000);

        // Release again: same start-up sequence as the first time
        @(negedge clk);
        cyc   = 0;
        reset = 1'b1;
        #1;
        expect_out(1'b0, 32'h0, 1'b0, 32'h0);
        step(32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000);
        step(32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting directly upstream of the single-cycle ARM core. Issues word requests to an instruction memory with variable acknowledge latency and prefetches sequential words into a small buffer. Presents `instr` to the core for the core's current `pc`, with `instr_valid` low while the word is not yet available. Detects a non-sequential `pc` (branch) as a redirect, flushes the buffer and restarts fetch at the new `pc`.

## Interface
- `DEPTH`, 2: prefetch buffer entries, legal 1..4.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'hE1A0_0000: word driven on `instr` when not valid (MOV r0,r0).

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `pc`  in  32  address of the instruction the core wants this cycle, word aligned.
- `stall`  in  1  core not consuming this cycle; suppresses pop.
- `instr`  out  32  instruction for `pc`; `NOP_INSTR` when `instr_valid`=0.
- `instr_valid`  out  1  `instr` is the word at `pc`.
- `imem_req`  out  1  request to instruction memory, registered.
- `imem_addr`  out  32  request address, registered, stable while `imem_req`=1 and not acked.
- `imem_ack`  in  1  memory accepted request; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  read data, sampled only when `imem_req`&`imem_ack`.

## Operation
- Buffer: FIFO of DEPTH entries {addr, data}; `count` 0..DEPTH.
- Hit (combinational): `count`>0 and head.addr==`pc` -> `instr`=head.data, `instr_valid`=1. Otherwise `instr_valid`=0, `instr`=`NOP_INSTR`.
- Pop: hit & !`stall` pops head at the edge.
- Redirect: `count`>0 and head.addr!=`pc`, or `count`==0 and no request in flight/pending for `pc` (i.e. `fetch_addr`!=`pc`). At edge: flush buffer, `fetch_addr`<=`pc`.
- `fetch_addr`: next address to request; +4 on each accepted (non-discarded) ack, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- At most one outstanding request. Request held (req, addr unchanged) until `imem_ack`; never withdrawn.
- FSM:
  - IDLE: `imem_req`=0. Next edge: if space -> REQ with `imem_addr`<=`fetch_addr`.
  - REQ: on ack without redirect, push {`imem_addr`, `imem_rdata`}, `fetch_addr`+=4; if space still available stay REQ with next address (back-to-back), else IDLE. Redirect without ack -> DISCARD. Redirect coinciding with ack -> data dropped, next request (if space) to `pc`.
  - DISCARD: request held at old address until ack; data dropped; then REQ at `fetch_addr` (=redirect `pc`, updated by any later redirect).
- Space: `count` after this edge's push/pop/flush < DEPTH.
- Push and pop in same edge legal; `count` unchanged.
- Misaligned `pc` bits [1:0] ignored in compare (treated as 0).

## Timing
- Reset (async assert, held): `count`=0, state IDLE, `fetch_addr`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=`NOP_INSTR`. Reset mid-request abandons it; memory side sees `imem_req` drop immediately.
- First edge after release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Miss latency, zero-wait memory: redirect seen in cycle t; request in t+1; ack t+1; `instr_valid`=1 in t+2. Each wait-state cycle adds one.
- Steady state, zero-wait memory, no stall: one instruction per cycle, no bubbles.
- `stall` held: buffer fills to DEPTH, then `imem_req` deasserts after current ack; resumes the cycle after the first pop.

## Test plan
- Reset release, `pc` walks 0,4,8…, ack every cycle: req addr 0 in cycle 1, `instr_valid` from cycle 2, then valid every cycle with matching rdata.
- Ack 3 cycles after each req: `imem_req`/`imem_addr` stable 3 cycles, `instr_valid` high one cycle per 4.
- Branch: buffer holds 0xC,0x10, `pc` jumps 0x8->0x100: flush, req 0x100 next cycle, valid 2 cycles after jump.
- Branch while req 0x10 pending (ack delayed 2): 0x10 held until ack, data dropped, then req 0x200; `instr_valid` never high for wrong word.
- DEPTH=2, `stall`=1 for 6 cycles: 2 entries fill, `imem_req` low, resumes one cycle after stall drops; no word lost or duplicated.
- `pc`=0xFFFF_FFFC sequential: next request 0x0000_0000; reset asserted mid-request: all outputs to reset values asynchronously.
